chaos_stream_cipher: RTL and testbench

Stream-encryption stage directly downstream of the logistic-map key core. It accepts plaintext words over a valid/ready handshake and requests one chaotic key word per plaintext word from the core (start/done handshake). It XORs the key into the data and presents the ciphertext over a valid/ready output. The returned key is chained back as the next seed, and a watchdog guards against a hung core.

---
 rtl/chaos_stream_cipher.sv | 176 +++++++++++++++++
 tb/tb_chaos_stream_cipher.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chaos_stream_cipher.sv
// Stream-encryption stage for the logistic-map key core.
// Each accepted plaintext word triggers one key request; the returned key is
// XORed into the word and chained back as the next seed. A saturating
// watchdog aborts a word if the core never produces a fresh done.
module chaos_stream_cipher #(
    parameter int DATA_WIDTH = 12,
    parameter int TIMEOUT    = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_load,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    input  logic [DATA_WIDTH-1:0] cfg_mu,
    input  logic [6:0]            cfg_iter,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  core_start,
    output logic [DATA_WIDTH-1:0] core_key1,
    output logic [DATA_WIDTH-1:0] core_key2,
    output logic [DATA_WIDTH-1:0] core_mu,
    input  logic [DATA_WIDTH-1:0] core_keyout,
    input  logic                  core_done,
    output logic                  busy,
    output logic                  err,
    output logic [15:0]           word_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t                  r_state;
    state_t                  w_state_next;

    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   r_seed;
    logic [DATA_WIDTH-1:0]   r_mu;
    logic [6:0]              r_iter;
    logic [7:0]              r_wdog;
    logic                    r_done_armed;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_valid;
    logic                    r_err;
    logic [15:0]             r_word_cnt;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_cfg_take;
    logic [7:0]              w_wdog_inc;
    logic                    w_timeout;
    logic                    w_capture;
    logic                    w_out_fire;
    logic [DATA_WIDTH-1:0]   w_next_seed;

    // Handshake qualifiers; a config load in IDLE blocks the same-cycle word
    // so the word always uses the freshly loaded seed.
    assign w_in_ready  = (r_state == S_IDLE) && !cfg_load && rst_n;
    assign w_accept    = w_in_ready && in_valid;
    assign w_cfg_take  = (r_state == S_IDLE) && cfg_load;
    assign w_wdog_inc  = (r_wdog == 8'hFF) ? r_wdog : r_wdog + 8'd1;
    assign w_timeout   = (r_state == S_WAIT) && (w_wdog_inc >= TIMEOUT_CNT);
    // Only a done seen high after a low sample belongs to this request.
    assign w_capture   = (r_state == S_WAIT) && core_done && r_done_armed && !w_timeout;
    assign w_out_fire  = (r_state == S_OUT) && r_out_valid && out_ready;
    // A zero key would pin the map at its fixed point, so reseed with 1.
    assign w_next_seed = (core_keyout == '0) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : core_keyout;

    assign in_ready   = w_in_ready;
    assign core_start = (r_state == S_REQ);
    assign busy       = (r_state != S_IDLE);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign core_key1  = r_seed;
    assign core_key2  = {{(DATA_WIDTH-7){1'b0}}, r_iter};
    assign core_mu    = r_mu;
    assign err        = r_err;
    assign word_cnt   = r_word_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept -> request -> wait for key -> present output.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_timeout) begin
                    w_state_next = S_IDLE;
                end else if (w_capture) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (w_out_fire) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: config, plaintext capture, watchdog, key mixing and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_seed       <= '0;
            r_mu         <= '0;
            r_iter       <= '0;
            r_wdog       <= '0;
            r_done_armed <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            if (w_cfg_take) begin
                r_seed     <= cfg_seed;
                r_mu       <= cfg_mu;
                r_iter     <= cfg_iter;
                r_err      <= 1'b0;
                r_word_cnt <= '0;
            end
            if (w_accept) begin
                r_data <= in_data;
            end
            if (r_state == S_REQ) begin
                r_wdog       <= '0;
                r_done_armed <= 1'b0;
            end
            if (r_state == S_WAIT) begin
                r_wdog <= w_wdog_inc;
                if (!core_done) begin
                    r_done_armed <= 1'b1;
                end
                if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
            if (w_capture) begin
                r_out_data  <= r_data ^ core_keyout;
                r_seed      <= w_next_seed;
                r_out_valid <= 1'b1;
            end
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_word_cnt  <= r_word_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_chaos_stream_cipher.sv
// Directed bench for chaos_stream_cipher with a small behavioural key core.
module tb_chaos_stream_cipher;

    localparam int DW      = 12;
    localparam int TIMEOUT = 200;
    localparam int CORE_N  = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_load = 1'b0;
    logic [DW-1:0] cfg_seed = '0;
    logic [DW-1:0] cfg_mu = '0;
    logic [6:0]    cfg_iter = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          core_start;
    logic [DW-1:0] core_key1;
    logic [DW-1:0] core_key2;
    logic [DW-1:0] core_mu;
    logic [DW-1:0] core_keyout = '0;
    logic          core_done = 1'b0;
    logic          busy;
    logic          err;
    logic [15:0]   word_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Key-core model controls
    logic [DW-1:0] m_key = '0;
    logic          m_stuck = 1'b0;
    int            m_cnt = 0;

    chaos_stream_cipher #(.DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_seed(cfg_seed),
        .cfg_mu(cfg_mu), .cfg_iter(cfg_iter), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_start(core_start), .core_key1(core_key1), .core_key2(core_key2),
        .core_mu(core_mu), .core_keyout(core_keyout), .core_done(core_done),
        .busy(busy), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Key core: drops done on start, raises it with the key N cycles later and
    // then holds the level; when stuck it ignores start and keeps done high.
    always @(posedge clk) begin
        if (core_start && !m_stuck) begin
            core_done <= 1'b0;
            m_cnt     <= CORE_N;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                core_done   <= 1'b1;
                core_keyout <= m_key;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic accept_and_wait(input logic [DW-1:0] exp_seed, output int lat);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("start_pulse", 32'(core_start), 32'd1);
        check("req_seed", 32'(core_key1), 32'(exp_seed));
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_word(input logic [DW-1:0] pt, input logic [DW-1:0] key,
                           input logic [DW-1:0] exp_seed, output int lat);
        m_key = key;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = pt;
        check("in_ready", 32'(in_ready), 32'd1);
        accept_and_wait(exp_seed, lat);
    endtask

    task automatic cfg(input logic [DW-1:0] s, input logic [DW-1:0] m, input logic [6:0] it);
        @(negedge clk);
        cfg_load = 1'b1; cfg_seed = s; cfg_mu = m; cfg_iter = it;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic hang_word(input logic [DW-1:0] pt, input logic [15:0] exp_cnt);
        int n;
        bit saw_ov;
        m_stuck = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = pt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        saw_ov = 1'b0;
        while (!err && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) saw_ov = 1'b1;
        end
        check("hang_err", 32'(err), 32'd1);
        check("hang_window", 32'(n >= TIMEOUT && n <= TIMEOUT + 2), 32'd1);
        check("hang_no_out", 32'(saw_ov), 32'd0);
        check("hang_idle", 32'(busy), 32'd0);
        check("hang_cnt", 32'(word_cnt), 32'(exp_cnt));
        m_stuck = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout: simulation exceeded its time limit");
        $fatal(1, "time limit");
    end

    initial begin
        int lat;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", 32'(word_cnt), 32'd0);
        check("rst_key1", 32'(core_key1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic word
        cfg(12'h400, 12'hF00, 7'd5);
        check("cfg_key1", 32'(core_key1), 32'h400);
        check("cfg_mu", 32'(core_mu), 32'hF00);
        check("cfg_key2", 32'(core_key2), 32'h005);
        do_word(12'h123, 12'hA5C, 12'h400, lat);
        check("basic_lat", 32'(lat), 32'd11);
        check("basic_data", 32'(out_data), 32'hB7F);
        check("basic_seed", 32'(core_key1), 32'hA5C);
        @(posedge clk); #1;
        check("basic_ov_one", 32'(out_valid), 32'd0);
        check("basic_cnt", 32'(word_cnt), 32'd1);
        check("basic_ready", 32'(in_ready), 32'd1);

        // Zero-key chaining
        do_word(12'h3C6, 12'h000, 12'hA5C, lat);
        check("zero_lat", 32'(lat), 32'd11);
        check("zero_data", 32'(out_data), 32'h3C6);
        check("zero_seed", 32'(core_key1), 32'h001);
        @(posedge clk); #1;
        check("zero_cnt", 32'(word_cnt), 32'd2);

        // Output backpressure
        out_ready = 1'b0;
        do_word(12'h0F0, 12'h5A5, 12'h001, lat);
        check("bp_lat", 32'(lat), 32'd11);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_ov", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'h555);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_cnt", 32'(word_cnt), 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ov", 32'(out_valid), 32'd0);
        check("bp_release_cnt", 32'(word_cnt), 32'd3);

        // Stale done / hung core
        hang_word(12'h999, 16'd3);

        // Reset mid-WAIT
        m_key = 12'h111;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 12'h0AB;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_err", 32'(err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_start", 32'(core_start), 32'd0);
        check("arst_ov", 32'(out_valid), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_cnt", 32'(word_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_word(12'h2AA, 12'h0F0, 12'h000, lat);
        check("post_lat", 32'(lat), 32'd11);
        check("post_data", 32'(out_data), 32'h25A);
        @(posedge clk); #1;
        check("post_cnt", 32'(word_cnt), 32'd1);

        // Second hang, then cfg_load clears err and count
        hang_word(12'h5C3, 16'd1);
        cfg(12'h222, 12'hE00, 7'd4);
        check("clr_err", 32'(err), 32'd0);
        check("clr_cnt", 32'(word_cnt), 32'd0);

        // Config-load collision
        m_key = 12'h3A1;
        @(negedge clk);
        cfg_load = 1'b1; cfg_seed = 12'h777; cfg_mu = 12'h800; cfg_iter = 7'd3;
        in_valid = 1'b1;
        in_data  = 12'h456;
        #1;
        check("coll_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        cfg_load = 1'b0;
        check("coll_not_taken", 32'(busy), 32'd0);
        check("coll_key1", 32'(core_key1), 32'h777);
        check("coll_key2", 32'(core_key2), 32'h003);
        check("coll_mu", 32'(core_mu), 32'h800);
        accept_and_wait(12'h777, lat);
        check("coll_lat", 32'(lat), 32'd11);
        check("coll_data", 32'(out_data), 32'h7F7);
        @(posedge clk); #1;
        check("coll_cnt", 32'(word_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
